// File: rtl/if_fetch_ctrl_pkg.sv
// if_fetch_ctrl_pkg: shared widths, PC step and sequencer state encodings
package if_fetch_ctrl_pkg;
  localparam int DEF_ADDRESS_LEN = 32;
  localparam int DEF_PC_STEP = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
endpackage

// File: rtl/if_fetch_ctrl_wait_counter.sv
// fetch_wait_counter: saturating memory-wait counter, tc while the count sits at TIMEOUT
module fetch_wait_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_tc
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] r_cnt;
  assign o_tc = r_cnt == W'(TIMEOUT);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else r_cnt <= i_clr ? '0 : (i_inc && !o_tc) ? r_cnt + W'(1) : r_cnt;
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: PC owner and imem handshake sequencer feeding the IF pipeline register
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int ADDRESS_LEN = DEF_ADDRESS_LEN,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC = '0,
  parameter int PC_STEP = DEF_PC_STEP,
  parameter int TIMEOUT = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_hazard,
  input  logic                   i_branch_taken,
  input  logic [ADDRESS_LEN-1:0] i_branch_addr,
  input  logic                   i_imem_ready,
  input  logic [ADDRESS_LEN-1:0] i_imem_rdata,
  output logic                   o_imem_req,
  output logic [ADDRESS_LEN-1:0] o_imem_addr,
  output logic [ADDRESS_LEN-1:0] o_ifr_pc,
  output logic [ADDRESS_LEN-1:0] o_ifr_instr,
  output logic                   o_ifr_freeze,
  output logic                   o_ifr_flush,
  output logic                   o_fetch_err
);
  logic [1:0]             r_state;
  logic [ADDRESS_LEN-1:0] r_pc, r_drain_addr, r_hold_buf, r_hold_pc, r_last_pc, r_last_instr;
  logic [ADDRESS_LEN-1:0] w_pc_inc;
  logic                   w_fetch_dlv, w_hold_dlv, w_deliver;
  assign w_pc_inc    = r_pc + ADDRESS_LEN'(PC_STEP);
  assign w_fetch_dlv = r_state == S_FETCH && i_imem_ready && !i_branch_taken && !i_hazard;
  assign w_hold_dlv  = r_state == S_HOLD && !i_branch_taken && !i_hazard;
  assign w_deliver   = w_fetch_dlv || w_hold_dlv;
  assign o_imem_req  = r_state == S_FETCH || r_state == S_DRAIN;
  assign o_imem_addr = r_state == S_DRAIN ? r_drain_addr : r_pc;
  assign o_ifr_pc    = w_fetch_dlv ? w_pc_inc : w_hold_dlv ? r_hold_pc : r_last_pc;
  assign o_ifr_instr = w_fetch_dlv ? i_imem_rdata : w_hold_dlv ? r_hold_buf : r_last_instr;
  // a redirect always bubbles, even over a hazard freeze
  assign o_ifr_flush  = i_branch_taken || (!i_hazard && !w_deliver);
  assign o_ifr_freeze = !i_branch_taken && i_hazard;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_drain_addr <= '0;
      r_hold_buf   <= '0;
      r_hold_pc    <= '0;
      r_last_pc    <= '0;
      r_last_instr <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH:
          if (i_branch_taken) begin
            r_pc <= i_branch_addr;
            if (!i_imem_ready) begin
              r_drain_addr <= r_pc;
              r_state      <= S_DRAIN;
            end
          end else if (i_imem_ready) begin
            r_pc <= w_pc_inc;
            if (i_hazard) begin
              r_hold_buf <= i_imem_rdata;
              r_hold_pc  <= w_pc_inc;
              r_state    <= S_HOLD;
            end
          end
        S_HOLD:
          if (i_branch_taken) begin
            r_pc    <= i_branch_addr;
            r_state <= S_FETCH;
          end else if (!i_hazard) r_state <= S_FETCH;
        default: begin
          if (i_branch_taken) r_pc <= i_branch_addr;
          if (i_imem_ready) r_state <= S_FETCH;
        end
      endcase
      if (w_deliver) begin
        r_last_pc    <= o_ifr_pc;
        r_last_instr <= o_ifr_instr;
      end
    end
  fetch_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_inc  (o_imem_req && !i_imem_ready),
    .i_clr  (i_imem_ready || !o_imem_req),
    .o_tc   (o_fetch_err)
  );
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed stimulus with a delivery scoreboard checked by a negedge monitor
module tb_if_fetch_ctrl;
  logic        clk = 0, rst_n = 0, hazard = 0, branch = 0, ready = 1;
  logic [31:0] baddr = 0, rdata, addr, ifr_pc, ifr_instr;
  logic        req, freeze, flush, err;
  int          checks = 0, failures = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;
  assign rdata = addr ^ 32'h5A5A_A5A5;

  if_fetch_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hazard(hazard), .i_branch_taken(branch),
    .i_branch_addr(baddr), .i_imem_ready(ready), .i_imem_rdata(rdata),
    .o_imem_req(req), .o_imem_addr(addr), .o_ifr_pc(ifr_pc), .o_ifr_instr(ifr_instr),
    .o_ifr_freeze(freeze), .o_ifr_flush(flush), .o_fetch_err(err)
  );

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] a);
    sb.push_back({pc, f(a)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (rst_n) begin
      chk("flush_freeze_exclusive", {31'd0, flush & freeze}, 0);
      if (!flush && !freeze) begin
        if (sb.size() == 0) chk("unexpected_delivery_pc", ifr_pc, 32'hxxxx_xxxx);
        else begin
          logic [63:0] e;
          e = sb.pop_front();
          chk("deliver_pc", ifr_pc, e[63:32]);
          chk("deliver_instr", ifr_instr, e[31:0]);
        end
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_flush", {31'd0, flush}, 1);
    chk("rst_freeze", {31'd0, freeze}, 0);
    chk("rst_ifr_pc", ifr_pc, 0);
    chk("rst_ifr_instr", ifr_instr, 0);
    chk("rst_err", {31'd0, err}, 0);
    step();
    rst_n = 1;
    for (int i = 0; i < 4; i++) push(4 * (i + 1), 4 * i);
    @(negedge clk);
    chk("idle_req", {31'd0, req}, 0);
    chk("idle_flush", {31'd0, flush}, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stream_addr", addr, 4 * i);
    end
    step();
    ready = 0;
    push(20, 16);
    push(24, 20);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 3; j++) begin
        ready = (j == 2);
        @(negedge clk);
        chk("slow_addr", addr, 16 + 4 * k);
        chk("slow_flush", {31'd0, flush}, {31'd0, j != 2});
        step();
      end
    ready = 1;
    hazard = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_freeze", {31'd0, freeze}, 1);
      chk("hold_req", {31'd0, req}, {31'd0, i == 0});
      step();
    end
    hazard = 0;
    push(28, 24);
    @(negedge clk);
    chk("hold_release_req", {31'd0, req}, 0);
    step();
    ready = 0;
    @(negedge clk);
    chk("after_hold_addr", addr, 28);
    step();
    branch = 1;
    baddr = 32'h200;
    hazard = 1;
    @(negedge clk);
    chk("br_haz_flush", {31'd0, flush}, 1);
    chk("br_haz_freeze", {31'd0, freeze}, 0);
    chk("br_haz_addr", addr, 28);
    step();
    branch = 0;
    hazard = 0;
    @(negedge clk);
    chk("drain_addr", addr, 28);
    chk("drain_req", {31'd0, req}, 1);
    chk("drain_flush", {31'd0, flush}, 1);
    step();
    branch = 1;
    baddr = 32'h300;
    ready = 1;
    @(negedge clk);
    chk("drain_br_addr", addr, 28);
    step();
    branch = 0;
    push(32'h304, 32'h300);
    @(negedge clk);
    chk("latest_target_addr", addr, 32'h300);
    step();
    branch = 1;
    baddr = 32'h400;
    @(negedge clk);
    chk("fetch_br_ready_addr", addr, 32'h304);
    chk("fetch_br_ready_flush", {31'd0, flush}, 1);
    step();
    branch = 0;
    push(32'h404, 32'h400);
    @(negedge clk);
    chk("redirect_addr", addr, 32'h400);
    step();
    branch = 1;
    baddr = 32'hFFFF_FFFC;
    @(negedge clk);
    step();
    branch = 0;
    push(0, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_src_addr", addr, 32'hFFFF_FFFC);
    step();
    ready = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 1) chk("wrap_addr", addr, 0);
      if (i == 255) chk("err_before", {31'd0, err}, 0);
      if (i == 256 || i == 300) chk("err_set", {31'd0, err}, 1);
      if (i == 150) chk("wait_addr_stable", addr, 0);
      step();
    end
    ready = 1;
    push(4, 0);
    @(negedge clk);
    chk("err_on_ready", {31'd0, err}, 1);
    step();
    ready = 0;
    @(negedge clk);
    chk("err_cleared", {31'd0, err}, 0);
    chk("post_err_addr", addr, 4);
    repeat (260) @(posedge clk);
    #1;
    chk("err_second_wait", {31'd0, err}, 1);
    #1;
    rst_n = 0;
    #1;
    chk("arst_req", {31'd0, req}, 0);
    chk("arst_addr", addr, 0);
    chk("arst_flush", {31'd0, flush}, 1);
    chk("arst_ifr_pc", ifr_pc, 0);
    chk("arst_ifr_instr", ifr_instr, 0);
    chk("arst_err", {31'd0, err}, 0);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Fetch sequencer for the instruction-fetch stage. Owns the PC and runs the request/ready handshake to instruction memory.
- Drives the freeze/flush/pc/instruction inputs of the IF stage pipeline register.
- Handles three conditions:
  - hazard stalls from the hazard unit;
  - taken-branch redirects from EXE;
  - multi-cycle memory latency, by inserting bubbles while memory is slow.

Parameters:
- ADDRESS_LEN, 32, width of PC, addresses and instruction words.
- RESET_PC, 0, first fetch address after reset.
- PC_STEP, 4, PC increment per delivered instruction.
- TIMEOUT, 255, wait cycles before fetch_err asserts (8-bit counter).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- hazard  in  1  stall request from hazard unit; level.
- branch_taken  in  1  one-cycle redirect pulse from EXE.
- branch_addr  in  ADDRESS_LEN  redirect target, valid with branch_taken.
- imem_ready  in  1  memory completes the outstanding request this cycle.
- imem_rdata  in  ADDRESS_LEN  instruction word, valid with imem_ready.
- imem_req  out  1  memory request.
- imem_addr  out  ADDRESS_LEN  request address.
- ifr_pc  out  ADDRESS_LEN  PC+PC_STEP of the delivered instruction, to the IF register pc_in.
- ifr_instr  out  ADDRESS_LEN  delivered instruction, to the IF register instruction_in.
- ifr_freeze  out  1  IF register freeze.
- ifr_flush  out  1  IF register flush (bubble).
- fetch_err  out  1  memory wait reached TIMEOUT.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC, hold_buf=0, wait_cnt=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, ifr_flush=1, ifr_freeze=0, ifr_pc=0, ifr_instr=0, fetch_err=0.
- Reset released mid-request: the request is abandoned and memory must tolerate this. The first cycle after release is IDLE; FETCH follows.
- Handshake rules:
  - While imem_req=1, imem_addr is held stable until the cycle imem_ready=1.
  - A request is never withdrawn early. imem_ready is ignored whenever imem_req=0.
- Output priority, evaluated every cycle: ifr_freeze and ifr_flush are never both 1. Highest priority first:
  1. branch_taken → flush=1.
  2. Else hazard → freeze=1.
  3. Else no instruction delivered → flush=1.
- IDLE: imem_req=0 → FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - branch_taken and imem_ready: discard data, pc←branch_addr, stay FETCH.
  - branch_taken and !imem_ready: drain_addr←pc, pc←branch_addr → DRAIN.
  - imem_ready and !hazard: deliver. ifr_instr=imem_rdata, ifr_pc=pc+PC_STEP, pc←pc+PC_STEP, stay FETCH. Latency is zero cycles from ready to the register inputs.
  - imem_ready and hazard: hold_buf←imem_rdata, hold_pc←pc+PC_STEP, pc←pc+PC_STEP → HOLD.
  - !imem_ready: no delivery.
- HOLD: imem_req=0.
  - branch_taken: discard hold_buf, pc←branch_addr → FETCH.
  - !hazard: deliver hold_buf/hold_pc → FETCH.
  - else stay HOLD with freeze=1.
- DRAIN: imem_req=1, imem_addr=drain_addr, no delivery.
  - imem_ready: data discarded → FETCH.
  - branch_taken in DRAIN: pc←branch_addr, stay DRAIN. The latest branch wins.
  - branch_taken and imem_ready in the same cycle: apply both, → FETCH at the new target.
- Arithmetic: PC increment wraps modulo 2^ADDRESS_LEN; 0xFFFFFFFC+4 = 0.
- Wait counter:
  - Increments each cycle with imem_req=1 and imem_ready=0, saturating at TIMEOUT.
  - Clears on imem_ready or on leaving a requesting state.
  - fetch_err=1 while wait_cnt==TIMEOUT. It is status only and does not alter sequencing.
- When not delivering, ifr_pc and ifr_instr hold their last delivered values.

Decomposition:
- Shared configs header: ADDRESS_LEN, state encodings (IDLE, FETCH, HOLD, DRAIN as a 2-bit localparam set), PC_STEP.
- One sub-module, fetch_wait_counter: saturating counter with inc, clr and tc outputs, parameterised on TIMEOUT.

Test Plan:
- Reset release, imem_ready tied 1, hazard=0 → imem_addr 0,4,8,12 on consecutive cycles; ifr_pc 4,8,12,16; first cycle after release shows ifr_flush=1.
- Memory ready every 3rd cycle → two flush bubbles per instruction; imem_addr stable across the wait cycles.
- hazard=1 for 4 cycles arriving with imem_ready at pc=0x10 → HOLD, freeze=1 for 4 cycles, imem_req=0; on release ifr_pc=0x14 with buffered instr; next request addr=0x14.
- branch_taken to 0x200 while a request at 0x40 is outstanding → DRAIN, imem_addr stays 0x40 until ready; 0x40 data never delivered; next request 0x200.
- branch_taken together with hazard=1 → flush=1, freeze=0 that cycle; pc=target.
- imem_ready held 0 for 300 cycles → fetch_err rises at wait cycle 255 and stays; clears the cycle after ready=1; rst=0 mid-wait → all outputs return to reset values immediately.
